// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl
//   Eight-digit seven-segment display controller. Two requesters write hex
//   digits into an 8-entry display buffer through valid/ready ports. A
//   round-robin arbiter with a 1-bit priority pointer grants at most one
//   write per cycle. Each buffer entry is decoded into an active-low segment
//   pattern. The outputs are combinational from the buffer registers, so new
//   data is visible right after the accepting edge.
//
//   Optional feature macro: SEG_BLINK_EN
//     defined   : a 32-bit blink prescaler and a phase bit are built, the
//                 per-digit blink flag is stored, and a blinking digit is
//                 blanked while the phase is 0.
//     undefined : no prescaler and no blink storage are built. The wrN_blink
//                 inputs and BLINK_CLK are ignored, and a digit is visible
//                 whenever its on bit is set.
//
// Ports
//   clk                  system clock
//   rst                  synchronous reset, active-high
//   wrN_valid / ready    requester N handshake (ready is combinational)
//   wrN_addr  [2:0]      target digit index
//   wrN_data  [3:0]      hex value
//   wrN_dp / on / blink  decimal point, digit enable, blink flag
//   o_seg0..o_seg7 [7:0] active-low segments, bit7=a .. bit1=g, bit0=dp
module seg_disp_ctrl #(
    parameter int unsigned BLINK_CLK = 32'd500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr0_valid,
    output logic       wr0_ready,
    input  logic [2:0] wr0_addr,
    input  logic [3:0] wr0_data,
    input  logic       wr0_dp,
    input  logic       wr0_on,
    input  logic       wr0_blink,
    input  logic       wr1_valid,
    output logic       wr1_ready,
    input  logic [2:0] wr1_addr,
    input  logic [3:0] wr1_data,
    input  logic       wr1_dp,
    input  logic       wr1_on,
    input  logic       wr1_blink,
    output logic [7:0] o_seg0,
    output logic [7:0] o_seg1,
    output logic [7:0] o_seg2,
    output logic [7:0] o_seg3,
    output logic [7:0] o_seg4,
    output logic [7:0] o_seg5,
    output logic [7:0] o_seg6,
    output logic [7:0] o_seg7
);

    // Hex value to active-high segment pattern a..g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0:    p = 7'b1111110;
            4'h1:    p = 7'b0110000;
            4'h2:    p = 7'b1101101;
            4'h3:    p = 7'b1111001;
            4'h4:    p = 7'b0110011;
            4'h5:    p = 7'b1011011;
            4'h6:    p = 7'b1011111;
            4'h7:    p = 7'b1110000;
            4'h8:    p = 7'b1111111;
            4'h9:    p = 7'b1111011;
            4'hA:    p = 7'b1110111;
            4'hB:    p = 7'b0011111;
            4'hC:    p = 7'b1001110;
            4'hD:    p = 7'b0111101;
            4'hE:    p = 7'b1001111;
            4'hF:    p = 7'b1000111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    logic       ptr_r;        // 0: requester 0 has priority on contention
    logic       grant0_s;
    logic       grant1_s;
    logic [2:0] wr_addr_s;
    logic [3:0] wr_data_s;
    logic       wr_dp_s;
    logic       wr_on_s;

    logic [3:0] data_r [8];
    logic       dp_r   [8];
    logic       on_r   [8];
    logic [7:0] seg_s  [8];

`ifdef SEG_BLINK_EN
    logic        wr_blink_s;
    logic        blink_r [8];
    logic [31:0] blink_cnt_r;
    logic        phase_r;
`else
    logic [33:0] unused_s;
    assign unused_s = {wr0_blink, wr1_blink, 32'(BLINK_CLK)};
`endif

    // Round-robin grant: a lone request always wins, the pointer breaks ties.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (wr0_valid && wr1_valid) begin
            if (ptr_r == 1'b0) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (wr0_valid) begin
            grant0_s = 1'b1;
        end else if (wr1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign wr0_ready = grant0_s;
    assign wr1_ready = grant1_s;

    // Priority pointer: after a grant, priority moves to the other port.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (grant0_s) begin
            ptr_r <= 1'b1;
        end else if (grant1_s) begin
            ptr_r <= 1'b0;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Write-port mux: select the fields of whichever port holds the grant.
    always_comb begin
        wr_addr_s = wr0_addr;
        wr_data_s = wr0_data;
        wr_dp_s   = wr0_dp;
        wr_on_s   = wr0_on;
`ifdef SEG_BLINK_EN
        wr_blink_s = wr0_blink;
`endif
        if (grant1_s) begin
            wr_addr_s = wr1_addr;
            wr_data_s = wr1_data;
            wr_dp_s   = wr1_dp;
            wr_on_s   = wr1_on;
`ifdef SEG_BLINK_EN
            wr_blink_s = wr1_blink;
`endif
        end else begin
            wr_addr_s = wr0_addr;
        end
    end

    // Display buffer: reset clears every digit; a granted write replaces all fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                data_r[k] <= 4'h0;
                dp_r[k]   <= 1'b0;
                on_r[k]   <= 1'b0;
`ifdef SEG_BLINK_EN
                blink_r[k] <= 1'b0;
`endif
            end
        end else if (grant0_s || grant1_s) begin
            data_r[wr_addr_s] <= wr_data_s;
            dp_r[wr_addr_s]   <= wr_dp_s;
            on_r[wr_addr_s]   <= wr_on_s;
`ifdef SEG_BLINK_EN
            blink_r[wr_addr_s] <= wr_blink_s;
`endif
        end
    end

`ifdef SEG_BLINK_EN
    // Blink prescaler: count 0..BLINK_CLK, toggle the phase on each wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_r <= 32'd0;
            phase_r     <= 1'b1;
        end else if (blink_cnt_r == 32'(BLINK_CLK)) begin
            blink_cnt_r <= 32'd0;
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + 32'd1;
        end
    end
`endif

    // Segment decode: blank (all ones) unless the digit is visible.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            logic vis_s;
`ifdef SEG_BLINK_EN
            vis_s = on_r[k] & ~(blink_r[k] & ~phase_r);
`else
            vis_s = on_r[k];
`endif
            if (vis_s) begin
                seg_s[k] = ~{hex_to_seg(data_r[k]), dp_r[k]};
            end else begin
                seg_s[k] = 8'hFF;
            end
        end
    end

    assign o_seg0 = seg_s[0];
    assign o_seg1 = seg_s[1];
    assign o_seg2 = seg_s[2];
    assign o_seg3 = seg_s[3];
    assign o_seg4 = seg_s[4];
    assign o_seg5 = seg_s[5];
    assign o_seg6 = seg_s[6];
    assign o_seg7 = seg_s[7];

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Testbench for seg_disp_ctrl: directed test-plan steps followed by
// randomized writes checked against a behavioural model of the display.
module tb_seg_disp_ctrl;

    localparam int BLINK = 3;

    // Decode table, active-high a..g.
    localparam logic [6:0] DEC [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic       clk = 1'b0;
    logic       rst;
    logic       wr0_valid, wr0_ready, wr0_dp, wr0_on, wr0_blink;
    logic [2:0] wr0_addr;
    logic [3:0] wr0_data;
    logic       wr1_valid, wr1_ready, wr1_dp, wr1_on, wr1_blink;
    logic [2:0] wr1_addr;
    logic [3:0] wr1_data;
    logic [7:0] o_seg0, o_seg1, o_seg2, o_seg3, o_seg4, o_seg5, o_seg6, o_seg7;
    logic [7:0] segs [8];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [3:0] m_data  [8];
    logic       m_dp    [8];
    logic       m_on    [8];
    logic       m_blink [8];
    int         m_ptr = 0;
    int         m_k   = 0;   // non-reset edges since the last reset

    always #5 clk = ~clk;

    seg_disp_ctrl #(.BLINK_CLK(BLINK)) dut (
        .clk(clk), .rst(rst),
        .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr),
        .wr0_data(wr0_data), .wr0_dp(wr0_dp), .wr0_on(wr0_on), .wr0_blink(wr0_blink),
        .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data), .wr1_dp(wr1_dp), .wr1_on(wr1_on), .wr1_blink(wr1_blink),
        .o_seg0(o_seg0), .o_seg1(o_seg1), .o_seg2(o_seg2), .o_seg3(o_seg3),
        .o_seg4(o_seg4), .o_seg5(o_seg5), .o_seg6(o_seg6), .o_seg7(o_seg7)
    );

    assign segs[0] = o_seg0;
    assign segs[1] = o_seg1;
    assign segs[2] = o_seg2;
    assign segs[3] = o_seg3;
    assign segs[4] = o_seg4;
    assign segs[5] = o_seg5;
    assign segs[6] = o_seg6;
    assign segs[7] = o_seg7;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Which port the model grants now: -1 none, 0 or 1.
    function automatic int model_grant();
        if (wr0_valid && wr1_valid) return m_ptr;
        if (wr0_valid) return 0;
        if (wr1_valid) return 1;
        return -1;
    endfunction

    function automatic logic [7:0] model_seg(input int k);
        logic phase;
        logic vis;
        phase = ((m_k / (BLINK + 1)) % 2) == 0;
`ifdef SEG_BLINK_EN
        vis = m_on[k] && !(m_blink[k] && !phase);
`else
        vis = m_on[k];
`endif
        return vis ? ~{DEC[m_data[k]], m_dp[k]} : 8'hFF;
    endfunction

    task automatic model_edge(input int g);
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                m_data[k] = 4'h0; m_dp[k] = 1'b0; m_on[k] = 1'b0; m_blink[k] = 1'b0;
            end
            m_ptr = 0;
            m_k   = 0;
        end else begin
            if (g == 0) begin
                m_data[wr0_addr] = wr0_data; m_dp[wr0_addr] = wr0_dp;
                m_on[wr0_addr] = wr0_on; m_blink[wr0_addr] = wr0_blink;
            end else if (g == 1) begin
                m_data[wr1_addr] = wr1_data; m_dp[wr1_addr] = wr1_dp;
                m_on[wr1_addr] = wr1_on; m_blink[wr1_addr] = wr1_blink;
            end
            if (g >= 0) m_ptr = 1 - g;
            m_k++;
        end
    endtask

    // One cycle: check readies, clock, update model, check all digits.
    task automatic tick(output logic r0, output logic r1);
        int g;
        #1;
        g  = model_grant();
        r0 = wr0_ready;
        r1 = wr1_ready;
        chk("ready0", {7'd0, wr0_ready}, {7'd0, 1'(g == 0)});
        chk("ready1", {7'd0, wr1_ready}, {7'd0, 1'(g == 1)});
        @(posedge clk);
        model_edge(g);
        #1;
        for (int k = 0; k < 8; k++) chk($sformatf("seg%0d", k), segs[k], model_seg(k));
    endtask

    task automatic p0(input logic v, input logic [2:0] a, input logic [3:0] d,
                      input logic dp, input logic on, input logic bl);
        wr0_valid = v; wr0_addr = a; wr0_data = d; wr0_dp = dp; wr0_on = on; wr0_blink = bl;
    endtask

    task automatic p1(input logic v, input logic [2:0] a, input logic [3:0] d,
                      input logic dp, input logic on, input logic bl);
        wr1_valid = v; wr1_addr = a; wr1_data = d; wr1_dp = dp; wr1_on = on; wr1_blink = bl;
    endtask

    task automatic do_reset();
        logic r0, r1;
        p0(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        p1(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(r0, r1);
        rst = 1'b0;
    endtask

    initial begin
        logic r0, r1;
        int   seen01, seenff;

        // Reset then idle
        do_reset();
        tick(r0, r1);
        chk("idle_ready0", {7'd0, r0}, 8'd0);
        chk("idle_ready1", {7'd0, r1}, 8'd0);
        for (int k = 0; k < 8; k++) chk($sformatf("idle_seg%0d", k), segs[k], 8'hFF);

        // Single write: addr3 = A with dp
        p0(1'b1, 3'd3, 4'hA, 1'b1, 1'b1, 1'b0);
        tick(r0, r1);
        p0(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("wr_a_seg3", o_seg3, 8'h10);
        chk("wr_a_seg2", o_seg2, 8'hFF);
        chk("wr_a_seg4", o_seg4, 8'hFF);

        // Continuous contention alternates 0,1,0,1
        do_reset();
        p0(1'b1, 3'd0, 4'h1, 1'b0, 1'b1, 1'b0);
        p1(1'b1, 3'd1, 4'h2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(r0, r1);
            chk($sformatf("alt%0d_r0", i), {7'd0, r0}, {7'd0, 1'(i % 2 == 0)});
            chk($sformatf("alt%0d_r1", i), {7'd0, r1}, {7'd0, 1'(i % 2 == 1)});
        end
        chk("alt_seg0", o_seg0, 8'h9F);
        chk("alt_seg1", o_seg1, 8'h25);

        // Same address from both: port 0 first, port 1 wins
        do_reset();
        p0(1'b1, 3'd5, 4'h7, 1'b0, 1'b1, 1'b0);
        p1(1'b1, 3'd5, 4'hE, 1'b0, 1'b1, 1'b0);
        tick(r0, r1);
        chk("same_first_r0", {7'd0, r0}, 8'd1);
        p0(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick(r0, r1);
        chk("same_second_r1", {7'd0, r1}, 8'd1);
        p1(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("same_seg5", o_seg5, 8'h61);

        // Reset during a granted write drops it and clears the pointer
        do_reset();
        p0(1'b1, 3'd0, 4'h3, 1'b0, 1'b1, 1'b0);
        tick(r0, r1);
        p0(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        p1(1'b1, 3'd6, 4'h5, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick(r0, r1);
        rst = 1'b0;
        p1(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick(r0, r1);
        chk("rst_seg6", o_seg6, 8'hFF);
        chk("rst_seg0", o_seg0, 8'hFF);
        p0(1'b1, 3'd1, 4'h4, 1'b0, 1'b1, 1'b0);
        p1(1'b1, 3'd2, 4'h4, 1'b0, 1'b1, 1'b0);
        tick(r0, r1);
        chk("rst_ptr_r0", {7'd0, r0}, 8'd1);
        p0(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        p1(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);

`ifdef SEG_BLINK_EN
        // Blinking digit 2 against steady digit 4
        do_reset();
        p0(1'b1, 3'd2, 4'h8, 1'b0, 1'b1, 1'b1);
        p1(1'b1, 3'd4, 4'h8, 1'b0, 1'b1, 1'b0);
        tick(r0, r1);
        p0(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        seen01 = 0;
        seenff = 0;
        for (int i = 0; i < 16; i++) begin
            tick(r0, r1);
            p1(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
            if (o_seg2 == 8'h01) seen01++;
            if (o_seg2 == 8'hFF) seenff++;
            chk("blink_steady_seg4", o_seg4, 8'h01);
        end
        chk("blink_seen_on",  8'(seen01 >= 6), 8'd1);
        chk("blink_seen_off", 8'(seenff >= 6), 8'd1);
`else
        seen01 = 0;
        seenff = 0;
`endif

        // Randomized writes; requesters hold a request until it is granted
        do_reset();
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!wr0_valid || r0 || rst)
                p0(1'($urandom_range(0, 2) != 0), 3'($urandom), 4'($urandom), 1'($urandom),
                   1'($urandom_range(0, 3) != 0), 1'($urandom));
            if (!wr1_valid || r1 || rst)
                p1(1'($urandom_range(0, 2) != 0), 3'($urandom), 4'($urandom), 1'($urandom),
                   1'($urandom_range(0, 3) != 0), 1'($urandom));
            rst = ($urandom_range(0, 39) == 0);
            tick(r0, r1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
